// File: rtl/data_memory_interface_pkg.sv
// Shared types and constants for the data memory interface: load/store
// format encodings (inst_funct3), FSM state type and timeout counter width.
package data_memory_interface_pkg;

   localparam logic [2:0] MEM_LB  = 3'b000;
   localparam logic [2:0] MEM_LH  = 3'b001;
   localparam logic [2:0] MEM_LW  = 3'b010;
   localparam logic [2:0] MEM_LBU = 3'b100;
   localparam logic [2:0] MEM_LHU = 3'b101;

   // Low two funct3 bits give the access size for both loads and stores.
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;

   localparam int DMI_TIMEOUT_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } dmi_state_t;

endpackage

// File: rtl/data_memory_interface_if.sv
// Word-bus side of the data memory interface; master drives requests,
// slave returns read data and ready.
interface data_memory_interface_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] bus_address;
   logic                  bus_read_enable;
   logic                  bus_write_enable;
   logic [3:0]            bus_byte_enable;
   logic [31:0]           bus_write_data;
   logic [31:0]           bus_read_data;
   logic                  bus_ready;

   modport master (
      output bus_address, bus_read_enable, bus_write_enable,
             bus_byte_enable, bus_write_data,
      input  bus_read_data, bus_ready
   );

   modport slave (
      input  bus_address, bus_read_enable, bus_write_enable,
             bus_byte_enable, bus_write_data,
      output bus_read_data, bus_ready
   );
endinterface

// File: rtl/data_memory_interface_load_store_aligner.sv
// Combinational lane logic: store byte enables / data replication,
// alignment check, and load byte/half extraction with extension.
module load_store_aligner
   import data_memory_interface_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   output logic        st_misaligned,
   input  logic [2:0]  ld_fmt,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        ld_sext;

   always_comb begin
      st_be         = 4'b1111;
      st_wdata      = st_data;
      st_misaligned = 1'b0;
      case (st_size)
         SIZE_BYTE: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         SIZE_HALF: begin
            st_be         = 4'b0011 << st_off;
            st_wdata      = {2{st_data[15:0]}};
            st_misaligned = st_off[0];
         end
         default: st_misaligned = |st_off;
      endcase
   end

   always_comb begin
      ld_byte = ld_word[8*ld_off +: 8];
      ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
      // funct3[2] selects the unsigned variants (LBU/LHU).
      ld_sext = ~ld_fmt[2];
      case (ld_fmt[1:0])
         SIZE_BYTE: ld_data = {{24{ld_byte[7] & ld_sext}}, ld_byte};
         SIZE_HALF: ld_data = {{16{ld_half[15] & ld_sext}}, ld_half};
         default:   ld_data = ld_word;
      endcase
   end
endmodule

// File: rtl/data_memory_interface.sv
// Core load/store to handshaked word-bus bridge with stall generation.
// Optional ACCESS timeout enabled by defining DATA_BUS_TIMEOUT_EN.
module data_memory_interface
   import data_memory_interface_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  core_read_enable,
   input  logic                  core_write_enable,
   input  logic [2:0]            core_format,
   input  logic [ADDR_WIDTH-1:0] core_address,
   input  logic [31:0]           core_write_data,
   output logic [31:0]           core_read_data,
   output logic                  stall,
   output logic                  misaligned,
   output logic                  bus_error,
   data_memory_interface_if.master bus
);
   dmi_state_t            state_q, state_d;
   logic [1:0]            off_q, off_d;
   logic [2:0]            fmt_q, fmt_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic                  bus_re_q, bus_re_d;
   logic                  bus_we_q, bus_we_d;
   logic [3:0]            bus_be_q, bus_be_d;
   logic [31:0]           bus_wd_q, bus_wd_d;
   logic                  mis_q, mis_d;

   logic        req;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic        st_mis;
   logic [31:0] ld_data;

   load_store_aligner u_aligner (
      .st_size      (core_format[1:0]),
      .st_off       (core_address[1:0]),
      .st_data      (core_write_data),
      .st_be        (st_be),
      .st_wdata     (st_wdata),
      .st_misaligned(st_mis),
      .ld_fmt       (fmt_q),
      .ld_off       (off_q),
      .ld_word      (rdata_q),
      .ld_data      (ld_data)
   );

   assign req = core_read_enable | core_write_enable;

`ifdef DATA_BUS_TIMEOUT_EN
   localparam logic [DMI_TIMEOUT_W-1:0] TO_LAST = DMI_TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   logic [DMI_TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                     bus_error_q, bus_error_d;
`else
   // TIMEOUT_CYCLES has no effect without the timeout feature.
   if (TIMEOUT_CYCLES > 0) begin : g_timeout_unused
   end
`endif

   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      fmt_d      = fmt_q;
      rdata_d    = rdata_q;
      bus_addr_d = bus_addr_q;
      bus_re_d   = bus_re_q;
      bus_we_d   = bus_we_q;
      bus_be_d   = bus_be_q;
      bus_wd_d   = bus_wd_q;
      mis_d      = 1'b0;
`ifdef DATA_BUS_TIMEOUT_EN
      cnt_d       = cnt_q;
      bus_error_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               off_d   = core_address[1:0];
               fmt_d   = core_format;
               rdata_d = '0;
               if (st_mis) begin
                  mis_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  // Write wins when both enables are high.
                  bus_addr_d = {core_address[ADDR_WIDTH-1:2], 2'b00};
                  bus_we_d   = core_write_enable;
                  bus_re_d   = ~core_write_enable;
                  bus_be_d   = core_write_enable ? st_be : 4'b1111;
                  bus_wd_d   = core_write_enable ? st_wdata : 32'h0;
                  state_d    = ACCESS;
`ifdef DATA_BUS_TIMEOUT_EN
                  cnt_d = '0;
`endif
               end
            end
         end
         ACCESS: begin
            if (bus.bus_ready) begin
               if (bus_re_q) rdata_d = bus.bus_read_data;
               bus_re_d = 1'b0;
               bus_we_d = 1'b0;
               state_d  = DONE;
            end
`ifdef DATA_BUS_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               rdata_d     = '0;
               bus_re_d    = 1'b0;
               bus_we_d    = 1'b0;
               bus_error_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         off_q      <= '0;
         fmt_q      <= '0;
         rdata_q    <= '0;
         bus_addr_q <= '0;
         bus_re_q   <= 1'b0;
         bus_we_q   <= 1'b0;
         bus_be_q   <= '0;
         bus_wd_q   <= '0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         fmt_q      <= fmt_d;
         rdata_q    <= rdata_d;
         bus_addr_q <= bus_addr_d;
         bus_re_q   <= bus_re_d;
         bus_we_q   <= bus_we_d;
         bus_be_q   <= bus_be_d;
         bus_wd_q   <= bus_wd_d;
         mis_q      <= mis_d;
      end
   end

`ifdef DATA_BUS_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         bus_error_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         bus_error_q <= bus_error_d;
      end
   end
   assign bus_error = bus_error_q;
`else
   assign bus_error = 1'b0;
`endif

   assign stall          = (state_q == ACCESS) || ((state_q == IDLE) && req);
   assign misaligned     = mis_q;
   assign core_read_data = (state_q == DONE) ? ld_data : 32'h0;

   assign bus.bus_address      = bus_addr_q;
   assign bus.bus_read_enable  = bus_re_q;
   assign bus.bus_write_enable = bus_we_q;
   assign bus.bus_byte_enable  = bus_be_q;
   assign bus.bus_write_data   = bus_wd_q;
endmodule
